// File: rtl/memory_server_pkg.sv
// Shared types, defaults and width helpers for the multi-channel memory server.
package memory_server_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_CHANNELS = 2;

    // Word-index width; a two-word memory still needs one address bit.
    function automatic int calc_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int calc_cw(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/memory_server_if.sv
// Requester-side bus of the memory server: one request/done lane per channel.
interface memory_server_if #(
    parameter int WIDTH    = memory_server_pkg::DEF_WIDTH,
    parameter int DEPTH    = memory_server_pkg::DEF_DEPTH,
    parameter int CHANNELS = memory_server_pkg::DEF_CHANNELS
);
    localparam int AW = memory_server_pkg::calc_aw(DEPTH);

    logic [CHANNELS-1:0]       req;
    logic [CHANNELS-1:0]       write;
    logic [CHANNELS*AW-1:0]    index;
    logic [CHANNELS*WIDTH-1:0] wdata;
    logic [CHANNELS-1:0]       done;
    logic [CHANNELS-1:0]       err;
    logic [CHANNELS*WIDTH-1:0] rdata;
    logic                      busy;

    modport master (
        output req, write, index, wdata,
        input  done, err, rdata, busy
    );

    modport slave (
        input  req, write, index, wdata,
        output done, err, rdata, busy
    );

endinterface

// File: rtl/memory_server_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible channel at or after
// the pointer; the pointer moves past the winner and holds when nobody wins.
module rr_arbiter #(
    parameter int CHANNELS = memory_server_pkg::DEF_CHANNELS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] eligible,
    output logic [CHANNELS-1:0] grant,
    output logic                grant_any
);
    import memory_server_pkg::*;

    localparam int PW = calc_cw(CHANNELS);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin : pick
        int c;
        c         = 0;
        grant     = '0;
        grant_any = 1'b0;
        ptr_d     = ptr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            c = (int'(ptr_q) + i) % CHANNELS;
            if (!grant_any && eligible[c]) begin
                grant[c]  = 1'b1;
                grant_any = 1'b1;
                ptr_d     = PW'((c + 1) % CHANNELS);
            end
        end
    end

    always_ff @(posedge clock) begin : ptr_reg
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/memory_server.sv
// Multi-channel memory server: clears storage after reset, then serves one
// read or write per cycle from round-robin arbitrated requester channels.
module memory_server #(
    parameter int WIDTH    = memory_server_pkg::DEF_WIDTH,
    parameter int DEPTH    = memory_server_pkg::DEF_DEPTH,
    parameter int CHANNELS = memory_server_pkg::DEF_CHANNELS
) (
    input logic            clock,
    input logic            reset,
    memory_server_if.slave bus
);
    import memory_server_pkg::*;

    localparam int AW = calc_aw(DEPTH);
    localparam int CW = calc_cw(CHANNELS);

    state_t                    state_q, state_d;
    logic [AW-1:0]             sweep_q, sweep_d;
    logic [CHANNELS-1:0]       done_q, done_d;
    logic [CHANNELS-1:0]       err_q, err_d;
    logic [CHANNELS-1:0]       sel_ram_q, sel_ram_d;
    logic [CHANNELS*WIDTH-1:0] hold_q, hold_d;
    logic [CHANNELS*WIDTH-1:0] rdata_o;

    logic [CHANNELS-1:0] eligible, grant;
    logic                grant_any;
    logic [CW-1:0]       g_idx;
    logic [AW-1:0]       g_index;
    logic [WIDTH-1:0]    g_wdata;
    logic                g_write, g_ok;

    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;
    logic [WIDTH-1:0] mem [DEPTH];

    // A channel whose done is showing this cycle sits out, so a held req is served once.
    assign eligible = (state_q == SERVE && !reset) ? (bus.req & ~done_q) : '0;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .eligible  (eligible),
        .grant     (grant),
        .grant_any (grant_any)
    );

    always_comb begin : encode
        g_idx = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant[c]) g_idx = CW'(c);
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == CLEAR) begin
            if (sweep_q == AW'(DEPTH - 1)) begin
                state_d = SERVE;
                sweep_d = '0;
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end
    end

    always_comb begin : datapath
        g_index   = bus.index[g_idx*AW +: AW];
        g_wdata   = bus.wdata[g_idx*WIDTH +: WIDTH];
        g_write   = bus.write[g_idx];
        g_ok      = 32'(g_index) < 32'(DEPTH);
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = g_index;
        ram_wdata = g_wdata;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = sweep_q;
            ram_wdata = '0;
        end else if (grant_any && g_ok) begin
            ram_we = g_write;
            ram_re = !g_write;
        end
        done_d    = grant;
        err_d     = (grant_any && !g_ok) ? grant : '0;
        sel_ram_d = ram_re ? grant : '0;
        // Each channel keeps whatever it last showed; out-of-range accesses zero it.
        hold_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hold_d[c*WIDTH +: WIDTH] = (grant[c] && !g_ok) ? '0 : rdata_o[c*WIDTH +: WIDTH];
        end
    end

    // The RAM's registered output is steered to the channel that read it for one
    // cycle; afterwards the per-channel hold register carries the value.
    always_comb begin : outputs
        for (int c = 0; c < CHANNELS; c++) begin
            rdata_o[c*WIDTH +: WIDTH] = sel_ram_q[c] ? ram_rdata : hold_q[c*WIDTH +: WIDTH];
        end
        bus.done  = done_q;
        bus.err   = err_q;
        bus.rdata = rdata_o;
        bus.busy  = (state_q == CLEAR);
    end

    always_ff @(posedge clock) begin : ram
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    always_ff @(posedge clock) begin : state_reg
        if (reset) begin
            state_q   <= CLEAR;
            sweep_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            sel_ram_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sel_ram_q <= sel_ram_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_memory_server.sv
// Bench for memory_server: directed vectors on a 16x16/2-channel instance and
// directed plus randomized traffic on a 12-word/3-channel instance.
module tb_memory_server;
    import memory_server_pkg::*;

    localparam int DA  = 16;
    localparam int CA  = 2;
    localparam int DB  = 12;
    localparam int CB  = 3;
    localparam int AWA = calc_aw(DA);
    localparam int AWB = calc_aw(DB);

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    memory_server_if #(.WIDTH(16), .DEPTH(DA), .CHANNELS(CA)) ifa ();
    memory_server_if #(.WIDTH(16), .DEPTH(DB), .CHANNELS(CB)) ifb ();

    memory_server #(.WIDTH(16), .DEPTH(DA), .CHANNELS(CA)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    memory_server #(.WIDTH(16), .DEPTH(DB), .CHANNELS(CB)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          wr;
        int          idx;
        logic [15:0] wd;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [8];

    // Reference model state for the randomized traffic on instance B.
    bit          b_req  [CB];
    bit          b_wr   [CB];
    int          b_idx  [CB];
    logic [15:0] b_wd   [CB];
    logic [15:0] m_mem  [DB];
    logic [15:0] m_rd   [CB];
    bit          m_done [CB];
    bit          m_err  [CB];
    int          m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit on_b, input int ch, input bit rq, input bit wr,
                         input int idx, input logic [15:0] wd);
        if (on_b) begin
            ifb.req[ch]                = rq;
            ifb.write[ch]              = wr;
            ifb.index[ch*AWB +: AWB]   = AWB'(idx);
            ifb.wdata[ch*16 +: 16]     = wd;
        end else begin
            ifa.req[ch]                = rq;
            ifa.write[ch]              = wr;
            ifa.index[ch*AWA +: AWA]   = AWA'(idx);
            ifa.wdata[ch*16 +: 16]     = wd;
        end
    endtask

    function automatic logic get_done(input bit on_b, input int ch);
        return on_b ? ifb.done[ch] : ifa.done[ch];
    endfunction

    function automatic logic get_err(input bit on_b, input int ch);
        return on_b ? ifb.err[ch] : ifa.err[ch];
    endfunction

    function automatic logic [15:0] get_rdata(input bit on_b, input int ch);
        return on_b ? ifb.rdata[ch*16 +: 16] : ifa.rdata[ch*16 +: 16];
    endfunction

    // Single transaction from one channel, requester side; called at a negedge.
    task automatic txn(input bit on_b, input int ch, input bit wr, input int idx,
                       input logic [15:0] wd, output logic [15:0] rd, output bit er,
                       output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        drive(on_b, ch, 1'b1, wr, idx, wd);
        while (!seen && lat < 20) begin
            @(negedge clock);
            lat++;
            seen = get_done(on_b, ch);
        end
        rd = get_rdata(on_b, ch);
        er = get_err(on_b, ch);
        drive(on_b, ch, 1'b0, wr, idx, wd);
        @(negedge clock);
        check("done_pulse", 64'(get_done(on_b, ch)), 64'd0);
    endtask

    task automatic txn_chk(input string name, input bit on_b, input int ch, input bit wr,
                           input int idx, input logic [15:0] wd, input logic [15:0] exp_rd,
                           input bit exp_er);
        logic [15:0] rd;
        bit          er;
        int          lat;
        txn(on_b, ch, wr, idx, wd, rd, er, lat);
        check({name, "_latency"}, 64'(lat), 64'd1);
        check({name, "_err"}, 64'(er), 64'(exp_er));
        if (!wr || exp_er) check({name, "_rdata"}, 64'(rd), 64'(exp_rd));
    endtask

    initial begin
        int          cnt_a;
        int          cnt_b;
        int          exp_ch;
        bit          bad;
        logic [15:0] fib [16];
        logic [1:0]  exp_vec;
        logic [CB-1:0]    ev_done;
        logic [CB-1:0]    ev_err;
        logic [CB*16-1:0] ev_rd;
        bit          found;
        int          g;
        int          c;

        reset = 1'b1;
        ifa.req = '0; ifa.write = '0; ifa.index = '0; ifa.wdata = '0;
        ifb.req = '0; ifb.write = '0; ifb.index = '0; ifb.wdata = '0;

        tbl[0] = '{1'b1, 3,  16'h0055, 16'h0000};
        tbl[1] = '{1'b0, 3,  16'h0000, 16'h0055};
        tbl[2] = '{1'b1, 15, 16'hBEEF, 16'h0000};
        tbl[3] = '{1'b0, 15, 16'h0000, 16'hBEEF};
        tbl[4] = '{1'b0, 0,  16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 7,  16'hA5A5, 16'h0000};
        tbl[6] = '{1'b0, 7,  16'h0000, 16'hA5A5};
        tbl[7] = '{1'b0, 3,  16'h0000, 16'h0055};

        repeat (3) @(negedge clock);
        check("rst_done_a",  64'(ifa.done),  64'd0);
        check("rst_err_a",   64'(ifa.err),   64'd0);
        check("rst_rdata_a", 64'(ifa.rdata), 64'd0);
        check("rst_busy_a",  64'(ifa.busy),  64'd1);
        check("rst_busy_b",  64'(ifb.busy),  64'd1);
        check("rst_rdata_b", 64'(ifb.rdata), 64'd0);

        reset = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 100; k++) begin
            if (!ifa.busy && !ifb.busy) break;
            if (ifa.busy) cnt_a++;
            if (ifb.busy) cnt_b++;
            @(negedge clock);
        end
        check("busy_len_a", 64'(cnt_a), 64'(DA));
        check("busy_len_b", 64'(cnt_b), 64'(DB));

        for (int i = 0; i < DA; i++) txn_chk("cleared_read", 1'b0, 0, 1'b0, i, 16'h0, 16'h0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            txn_chk("table", 1'b0, 0, tbl[i].wr, tbl[i].idx, tbl[i].wd, tbl[i].rd, 1'b0);
        end

        // The last grant went to ch0, so ch1 wins the first contested cycle.
        drive(1'b0, 0, 1'b1, 1'b1, 3, 16'h1234);
        drive(1'b0, 1, 1'b1, 1'b0, 3, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            exp_ch  = (k % 2 == 0) ? 1 : 0;
            exp_vec = 2'(1 << exp_ch);
            check("alt_grant", 64'(ifa.done), 64'(exp_vec));
            if (exp_ch == 1) check("alt_rdata", 64'(ifa.rdata[31:16]), (k == 0) ? 64'h0055 : 64'h1234);
        end
        drive(1'b0, 0, 1'b0, 1'b1, 3, 16'h1234);
        @(negedge clock);
        check("alt_tail", 64'(ifa.done), 64'b10);
        check("alt_tail_rdata", 64'(ifa.rdata[31:16]), 64'h1234);
        drive(1'b0, 1, 1'b0, 1'b0, 3, 16'h0000);
        @(negedge clock);
        check("alt_idle", 64'(ifa.done), 64'd0);

        fib[0] = 16'd0;
        fib[1] = 16'd1;
        for (int i = 2; i < 16; i++) fib[i] = fib[i-1] + fib[i-2];
        for (int i = 0; i < 16; i++) txn_chk("fib_wr", 1'b0, 0, 1'b1, i, fib[i], 16'h0, 1'b0);
        for (int i = 0; i < 16; i++) txn_chk("fib_rd", 1'b0, 0, 1'b0, i, 16'h0, fib[i], 1'b0);

        txn_chk("b_wr5",     1'b1, 1, 1'b1, 5,  16'h7777, 16'h0,    1'b0);
        txn_chk("b_rd5",     1'b1, 1, 1'b0, 5,  16'h0,    16'h7777, 1'b0);
        txn_chk("b_rd13",    1'b1, 1, 1'b0, 13, 16'h0,    16'h0,    1'b1);
        txn_chk("b_wr13",    1'b1, 1, 1'b1, 13, 16'hFFFF, 16'h0,    1'b1);
        txn_chk("b_wr12",    1'b1, 2, 1'b1, 12, 16'hABCD, 16'h0,    1'b1);
        txn_chk("b_rd1",     1'b1, 1, 1'b0, 1,  16'h0,    16'h0,    1'b0);
        txn_chk("b_rd11",    1'b1, 2, 1'b0, 11, 16'h0,    16'h0,    1'b0);
        txn_chk("b_rd5_again", 1'b1, 0, 1'b0, 5, 16'h0,   16'h7777, 1'b0);

        // Reset lands together with a fresh read of a written word on ch0.
        drive(1'b0, 0, 1'b1, 1'b0, 7, 16'h0);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("midrst_no_done", 64'(ifa.done), 64'd0);
            check("midrst_busy",    64'(ifa.busy), 64'd1);
        end
        check("midrst_rdata", 64'(ifa.rdata), 64'd0);
        reset = 1'b0;
        cnt_a = 0;
        bad   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!ifa.busy) break;
            cnt_a++;
            if (ifa.done != 2'b00) bad = 1'b1;
            @(negedge clock);
        end
        check("midrst_busy_len", 64'(cnt_a), 64'(DA));
        check("midrst_clear_no_done", 64'(bad), 64'd0);
        check("first_grant_not_early", 64'(ifa.done), 64'd0);
        @(negedge clock);
        check("first_grant", 64'(ifa.done), 64'b01);
        check("midrst_word_cleared", 64'(ifa.rdata[15:0]), 64'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 7, 16'h0);
        @(negedge clock);

        for (int i = 0; i < CB; i++) begin
            b_req[i] = 1'b0; b_wr[i] = 1'b0; b_idx[i] = 0; b_wd[i] = 16'h0;
            m_rd[i] = 16'h0; m_done[i] = 1'b0; m_err[i] = 1'b0;
        end
        for (int i = 0; i < DB; i++) m_mem[i] = 16'h0;
        m_ptr = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            for (int i = 0; i < CB; i++) begin
                ev_done[i]          = m_done[i];
                ev_err[i]           = m_err[i];
                ev_rd[i*16 +: 16]   = m_rd[i];
            end
            check("rand_done",  64'(ifb.done),  64'(ev_done));
            check("rand_err",   64'(ifb.err),   64'(ev_err));
            check("rand_rdata", 64'(ifb.rdata), 64'(ev_rd));

            for (int i = 0; i < CB; i++) begin
                if ((b_req[i] && m_done[i] && $urandom_range(0, 1) == 1) ||
                    (!b_req[i] && $urandom_range(0, 2) == 0)) begin
                    b_req[i] = 1'b1;
                    b_wr[i]  = 1'($urandom_range(0, 1));
                    b_idx[i] = int'($urandom_range(0, 15));
                    b_wd[i]  = 16'($urandom);
                end else if (b_req[i] && m_done[i]) begin
                    b_req[i] = 1'b0;
                end
                drive(1'b1, i, b_req[i], b_wr[i], b_idx[i], b_wd[i]);
            end

            // Model the next clock edge: first waiting requester from the pointer onward.
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < CB; k++) begin
                c = (m_ptr + k) % CB;
                if (!found && b_req[c] && !m_done[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            for (int i = 0; i < CB; i++) begin
                m_done[i] = 1'b0;
                m_err[i]  = 1'b0;
            end
            if (found) begin
                m_done[g] = 1'b1;
                m_ptr     = (g + 1) % CB;
                if (b_idx[g] >= DB) begin
                    m_err[g] = 1'b1;
                    m_rd[g]  = 16'h0;
                end else if (b_wr[g]) begin
                    m_mem[b_idx[g]] = b_wd[g];
                end else begin
                    m_rd[g] = m_mem[b_idx[g]];
                end
            end
        end
        ifb.req = '0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
